// File: rtl/gpu_pkg.sv
// Shared types and constants for the triangle fetch path.
// No logic here: enums, beat counts and the width of the beat counter.
// Imported by triangle_fetch and its AXI4-lite read port.
package gpu_pkg;

  // AXI read response codes; anything other than OKAY marks the fetch as failed
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  localparam int VERTEX_WORDS = 5;  // 9 packed 16-bit coordinates -> 5 words
  localparam int FETCH_BEATS  = 6;  // vertex words followed by the colour word
  localparam int BEAT_CNT_W   = 3;

  localparam logic [BEAT_CNT_W-1:0] COLOR_BEAT = BEAT_CNT_W'(VERTEX_WORDS);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(FETCH_BEATS - 1);

  // Beat sequencer states owned by triangle_fetch
  typedef enum logic [1:0] {
    FS_IDLE,
    FS_ADDR,
    FS_DATA
  } fetch_state_t;

  // Handshake engine states owned by axi_lite_read_port
  typedef enum logic [1:0] {
    RP_IDLE,
    RP_ADDR,
    RP_DATA
  } port_state_t;

endpackage

// File: rtl/axi_lite_read_port.sv
// Single-beat AXI4-lite read engine: one request in, one response out, one outstanding.
// Latency: arvalid the cycle after i_req, data returned combinationally on the R handshake.
// Backpressure: holds arvalid/araddr until arready; rready held until rvalid.
module axi_lite_read_port
  import gpu_pkg::*;
#(
  parameter int MADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // request side
  input  logic                   i_req,
  input  logic [MADDR_WIDTH-1:0] i_addr,
  output logic                   o_ar_hs,
  output logic                   o_done,
  output logic [31:0]            o_rdata,
  output axi_resp_t              o_rresp,
  // AXI4-lite read channels
  output logic [MADDR_WIDTH-1:0] o_araddr,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  input  logic [31:0]            i_rdata,
  input  logic [1:0]             i_rresp,
  input  logic                   i_rvalid,
  output logic                   o_rready
);

  port_state_t            r_state;
  port_state_t            w_state_nxt;
  logic [MADDR_WIDTH-1:0] r_araddr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RP_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Address latch: only written on a new request, so it stays put while waiting on arready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_araddr <= '0;
    else if (i_req) r_araddr <= i_addr;
  end

  // Next state; a request arriving with the R handshake chains straight into the next AR
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RP_IDLE: if (i_req) w_state_nxt = RP_ADDR;
      RP_ADDR: if (i_arready) w_state_nxt = RP_DATA;
      RP_DATA: if (i_rvalid) w_state_nxt = i_req ? RP_ADDR : RP_IDLE;
      default: w_state_nxt = RP_IDLE;
    endcase
  end

  assign o_arvalid = (r_state == RP_ADDR);
  assign o_rready  = (r_state == RP_DATA);
  assign o_araddr  = r_araddr;
  assign o_ar_hs   = o_arvalid & i_arready;
  assign o_done    = o_rready & i_rvalid;
  assign o_rdata   = i_rdata;
  assign o_rresp   = axi_resp_t'(i_rresp);

endmodule

// File: rtl/triangle_fetch.sv
// Fetches one triangle (9 coordinates + colour) over AXI4-lite and publishes it atomically.
// Latency: 13 cycles start-to-eoc with a zero-wait slave; each stall cycle adds one.
// Backpressure: one read outstanding; waits indefinitely on arready/rvalid, start ignored when busy.
module triangle_fetch
  import gpu_pkg::*;
#(
  parameter int MADDR_WIDTH = 32,
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [MADDR_WIDTH-1:0]                addr_vertex,
  input  logic [MADDR_WIDTH-1:0]                addr_colors,
  output logic [2:0][2:0][COORD_WIDTH-1:0]      vertexes,
  output logic [COLOR_WIDTH-1:0]                colors,
  output logic                                  eoc,
  output logic                                  error,
  output logic [MADDR_WIDTH-1:0]                araddr_m,
  output logic [2:0]                            arprot_m,
  output logic                                  arvalid_m,
  input  logic                                  arready_m,
  input  logic [31:0]                           rdata_m,
  input  logic [1:0]                            rresp_m,
  input  logic                                  rvalid_m,
  output logic                                  rready_m
);

  localparam logic [MADDR_WIDTH-1:0] LOW_BITS = MADDR_WIDTH'(3);
  localparam int                     N_COORD  = 2 * VERTEX_WORDS - 1;

  fetch_state_t               r_state;
  fetch_state_t               w_state_nxt;
  logic [MADDR_WIDTH-1:0]     r_base_vtx;
  logic [MADDR_WIDTH-1:0]     r_base_col;
  logic [BEAT_CNT_W-1:0]      r_beat;
  logic [BEAT_CNT_W-1:0]      w_beat_nxt;
  logic [MADDR_WIDTH-1:0]     w_vtx_beat_addr;
  logic                       w_req;
  logic [MADDR_WIDTH-1:0]     w_req_addr;
  logic                       w_ar_hs;
  logic                       w_rd_done;
  logic [31:0]                w_rdata;
  axi_resp_t                  w_rresp;
  logic                       w_accept;
  logic                       w_capture;
  logic                       w_last;
  logic                       r_error;
  logic [COORD_WIDTH-1:0]     r_coord_sh [N_COORD];
  logic [2:0][2:0][COORD_WIDTH-1:0] r_vertexes;
  logic [COLOR_WIDTH-1:0]     r_colors;

  function automatic logic [MADDR_WIDTH-1:0] word_align(input logic [MADDR_WIDTH-1:0] a);
    return a & ~LOW_BITS;
  endfunction

  assign w_accept        = (r_state == FS_IDLE) && start;
  assign w_capture       = (r_state == FS_DATA) && w_rd_done;
  assign w_last          = (r_beat == LAST_BEAT);
  assign w_beat_nxt      = r_beat + 1'b1;
  // Modulo-2^MADDR_WIDTH add: a record straddling the top of memory wraps to 0
  assign w_vtx_beat_addr = r_base_vtx + {{(MADDR_WIDTH-BEAT_CNT_W-2){1'b0}}, w_beat_nxt, 2'b00};

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FS_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and read request; the next beat is requested on the R handshake of the previous one
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_req_addr  = '0;
    case (r_state)
      FS_IDLE: begin
        if (start) begin
          w_state_nxt = FS_ADDR;
          w_req       = 1'b1;
          w_req_addr  = word_align(addr_vertex);
        end
      end
      FS_ADDR: begin
        if (w_ar_hs) w_state_nxt = FS_DATA;
      end
      FS_DATA: begin
        if (w_rd_done) begin
          if (w_last) begin
            w_state_nxt = FS_IDLE;
          end else begin
            w_state_nxt = FS_ADDR;
            w_req       = 1'b1;
            w_req_addr  = (w_beat_nxt == COLOR_BEAT) ? r_base_col : w_vtx_beat_addr;
          end
        end
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // Fetch context: aligned bases, beat counter and the sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base_vtx <= '0;
      r_base_col <= '0;
      r_beat     <= '0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      r_base_vtx <= word_align(addr_vertex);
      r_base_col <= word_align(addr_colors);
      r_beat     <= '0;
      r_error    <= 1'b0;
    end else if (w_capture) begin
      r_beat <= w_beat_nxt;
      if (w_rresp != RESP_OKAY) r_error <= 1'b1;
    end
  end

  // Shadow coordinates: word k carries coordinates 2k (low half) and 2k+1 (high half)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_COORD; i++) r_coord_sh[i] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < VERTEX_WORDS - 1; k++) begin
        if (r_beat == BEAT_CNT_W'(k)) begin
          r_coord_sh[2*k]   <= w_rdata[COORD_WIDTH-1:0];
          r_coord_sh[2*k+1] <= w_rdata[2*COORD_WIDTH-1:COORD_WIDTH];
        end
      end
      // Last vertex word holds only coordinate 8; its upper half is padding
      if (r_beat == BEAT_CNT_W'(VERTEX_WORDS - 1))
        r_coord_sh[N_COORD-1] <= w_rdata[COORD_WIDTH-1:0];
    end
  end

  // Published triangle: updated only on the final beat, the same edge that raises eoc
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vertexes <= '0;
      r_colors   <= '0;
    end else if (w_capture && w_last) begin
      for (int v = 0; v < 3; v++)
        for (int c = 0; c < 3; c++)
          r_vertexes[v][c] <= r_coord_sh[3*v+c];
      r_colors <= w_rdata[COLOR_WIDTH-1:0];
    end
  end

  axi_lite_read_port #(
    .MADDR_WIDTH (MADDR_WIDTH)
  ) u_read_port (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (w_req),
    .i_addr    (w_req_addr),
    .o_ar_hs   (w_ar_hs),
    .o_done    (w_rd_done),
    .o_rdata   (w_rdata),
    .o_rresp   (w_rresp),
    .o_araddr  (araddr_m),
    .o_arvalid (arvalid_m),
    .i_arready (arready_m),
    .i_rdata   (rdata_m),
    .i_rresp   (rresp_m),
    .i_rvalid  (rvalid_m),
    .o_rready  (rready_m)
  );

  assign eoc      = (r_state == FS_IDLE);
  assign error    = r_error;
  assign vertexes = r_vertexes;
  assign colors   = r_colors;
  assign arprot_m = 3'b000;

endmodule

// File: tb/tb_triangle_fetch.sv
// Randomized bench for triangle_fetch against a memory-image reference model.
// The slave model stalls AR/R randomly and can inject a non-OKAY response on a chosen beat.
// Expected coordinates are derived from the word layout, not from the DUT.
module tb_triangle_fetch;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] addr_vertex, addr_colors;
  logic [2:0][2:0][15:0] vertexes;
  logic [15:0] colors;
  logic        eoc, error;
  logic [31:0] araddr_m;
  logic [2:0]  arprot_m;
  logic        arvalid_m, arready_m;
  logic [31:0] rdata_m;
  logic [1:0]  rresp_m;
  logic        rvalid_m, rready_m;

  always #5 clk = ~clk;

  triangle_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .addr_vertex(addr_vertex), .addr_colors(addr_colors),
    .vertexes(vertexes), .colors(colors), .eoc(eoc), .error(error),
    .araddr_m(araddr_m), .arprot_m(arprot_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rdata_m(rdata_m), .rresp_m(rresp_m), .rvalid_m(rvalid_m), .rready_m(rready_m)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory image and slave ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_q [$];
  int          stall    = 0;
  int          err_beat = -1;
  logic [1:0]  err_resp = 2'b10;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic        pend, ar_hs, r_hs, prev_wait;
    logic [31:0] pend_addr, prev_addr;
    int          pend_beat, dly;
    pend = 0; prev_wait = 0; prev_addr = '0; pend_addr = '0; pend_beat = 0; dly = 0;
    arready_m = 1'b0; rvalid_m = 1'b0; rdata_m = '0; rresp_m = '0;
    forever begin
      @(negedge clk);
      ar_hs = reset_n && arvalid_m && arready_m;
      r_hs  = reset_n && rvalid_m && rready_m;
      if (reset_n) begin
        chk("ar_r_exclusive", {63'd0, arvalid_m & rready_m}, 64'd0);
        if (prev_wait) begin
          chk("arvalid_held", {63'd0, arvalid_m}, 64'd1);
          chk("araddr_stable", {32'd0, araddr_m}, {32'd0, prev_addr});
        end
      end
      prev_wait = reset_n && arvalid_m && !arready_m;
      prev_addr = araddr_m;
      if (ar_hs) begin
        pend_beat = ar_q.size();
        pend_addr = araddr_m;
        ar_q.push_back(araddr_m);
      end
      @(posedge clk); #1;
      if (!reset_n) begin
        pend = 0; rvalid_m = 1'b0;
      end else begin
        if (r_hs) rvalid_m = 1'b0;
        if (ar_hs) begin
          pend = 1;
          dly  = (stall == 0) ? 0 : $urandom_range(0, stall);
        end
        if (pend && !rvalid_m) begin
          if (dly == 0) begin
            rvalid_m = 1'b1;
            rdata_m  = mem_rd(pend_addr);
            rresp_m  = (pend_beat == err_beat) ? err_resp : 2'b00;
            pend     = 0;
          end else dly--;
        end
      end
      arready_m = (stall == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_addr [$];
  logic [15:0] exp_coord [9];
  logic [15:0] exp_col;
  logic        exp_err;

  task automatic prepare(input logic [31:0] vb, input logic [31:0] cb, input bit fill, input int eb);
    logic [31:0] base, w;
    exp_addr.delete();
    base = vb & ~32'd3;
    for (int k = 0; k < 5; k++) exp_addr.push_back(base + 32'(4 * k));
    exp_addr.push_back(cb & ~32'd3);
    if (fill) foreach (exp_addr[k]) mem[exp_addr[k]] = $urandom;
    for (int i = 0; i < 9; i++) begin
      w = mem_rd(exp_addr[i / 2]);
      exp_coord[i] = (i % 2 == 1) ? w[31:16] : w[15:0];
    end
    w = mem_rd(exp_addr[5]);
    exp_col  = w[15:0];
    exp_err  = (eb >= 0 && eb < 6);
    err_beat = eb;
  endtask

  task automatic do_start(input string name, input logic [31:0] vb, input logic [31:0] cb);
    @(posedge clk); #2;
    addr_vertex = vb; addr_colors = cb;
    ar_q.delete();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk({name, "_eoc_n1"}, {63'd0, eoc}, 64'd0);
    chk({name, "_arvalid_n1"}, {63'd0, arvalid_m}, 64'd1);
    chk({name, "_error_clr_n1"}, {63'd0, error}, 64'd0);
    chk({name, "_araddr0"}, {32'd0, araddr_m}, {32'd0, exp_addr[0]});
  endtask

  task automatic wait_done(input string name, input int mid_start, output int cycles);
    logic [2:0][2:0][15:0] v0;
    logic [15:0] c0;
    bit stable;
    v0 = vertexes; c0 = colors; stable = 1; cycles = 1;
    while (!eoc && cycles < 3000) begin
      if (cycles == mid_start) begin
        start = 1'b1; addr_vertex = 32'h0000_5550; addr_colors = 32'h0000_6660;
      end else start = 1'b0;
      @(posedge clk); #2;
      cycles++;
      if (!eoc && (vertexes !== v0 || colors !== c0)) stable = 0;
    end
    start = 1'b0;
    chk({name, "_timeout"}, {63'd0, cycles >= 3000}, 64'd0);
    chk({name, "_stable_in_fetch"}, {63'd0, stable}, 64'd1);
  endtask

  task automatic check_results(input string name);
    chk({name, "_ar_count"}, 64'(ar_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < ar_q.size(); k++)
      chk($sformatf("%s_addr%0d", name, k), {32'd0, ar_q[k]}, {32'd0, exp_addr[k]});
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        chk($sformatf("%s_v%0d_c%0d", name, v, c), {48'd0, vertexes[v][c]}, {48'd0, exp_coord[3*v+c]});
    chk({name, "_colors"}, {48'd0, colors}, {48'd0, exp_col});
    chk({name, "_error"}, {63'd0, error}, {63'd0, exp_err});
    chk({name, "_eoc"}, {63'd0, eoc}, 64'd1);
  endtask

  task automatic run_fetch(input string name, input logic [31:0] vb, input logic [31:0] cb,
                           input bit fill, input int eb, input int mid_start, input bit zero_wait);
    int cyc;
    prepare(vb, cb, fill, eb);
    do_start(name, vb, cb);
    wait_done(name, mid_start, cyc);
    if (zero_wait) chk({name, "_latency"}, 64'(cyc), 64'd13);
    check_results(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] vb, cb;
    reset_n = 1'b0; start = 1'b0; addr_vertex = '0; addr_colors = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_eoc", {63'd0, eoc}, 64'd1);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_arvalid", {63'd0, arvalid_m}, 64'd0);
    chk("rst_rready", {63'd0, rready_m}, 64'd0);
    chk("rst_araddr", {32'd0, araddr_m}, 64'd0);
    chk("rst_vertexes", {48'd0, vertexes[0][0] | vertexes[1][1] | vertexes[2][2]}, 64'd0);
    chk("rst_colors", {48'd0, colors}, 64'd0);
    chk("arprot", {61'd0, arprot_m}, 64'd0);

    // Directed zero-wait record
    stall = 0;
    mem[32'h100] = 32'h0000_0000; mem[32'h104] = 32'h0000_0320; mem[32'h108] = 32'h0320_0000;
    mem[32'h10C] = 32'h0258_0000; mem[32'h110] = 32'h0000_0000; mem[32'h200] = 32'h0000_FFFF;
    run_fetch("dir", 32'h100, 32'h200, 0, -1, -1, 1);
    chk("dir_v0z_800", {48'd0, vertexes[0][2]}, 64'd800);
    chk("dir_v2y_600", {48'd0, vertexes[2][1]}, 64'd600);
    chk("dir_color_ffff", {48'd0, colors}, 64'h0000_FFFF);

    // Random stalls, random bases, random error injection
    for (int t = 0; t < 10; t++) begin
      stall    = $urandom_range(1, 5);
      err_resp = 2'($urandom_range(1, 3));
      vb = $urandom;
      cb = vb ^ 32'h0001_0000;
      run_fetch($sformatf("rnd%0d", t), vb, cb, 1, $urandom_range(0, 9), -1, 0);
    end

    // Unaligned base plus a start pulse while busy
    stall = 2;
    run_fetch("unal", 32'h0000_1003, 32'h0000_2002, 1, -1, 4, 0);
    repeat (3) @(posedge clk); #2;
    chk("unal_no_refetch", {63'd0, arvalid_m}, 64'd0);
    chk("unal_ar_total", 64'(ar_q.size()), 64'd6);

    // SLVERR on vertex word 2, then a clean fetch must clear error at N+1
    stall = 0; err_resp = 2'b10;
    run_fetch("slverr", 32'h0000_3000, 32'h0000_3100, 1, 2, -1, 1);
    run_fetch("after_err", 32'h0000_3200, 32'h0000_3300, 1, -1, -1, 1);

    // Address wrap at the top of memory
    run_fetch("wrap", 32'hFFFF_FFF8, 32'h0000_0040, 1, -1, -1, 1);

    // Reset in the DATA phase of beat 3
    stall = 0;
    prepare(32'h0000_4000, 32'h0000_4100, 1, -1);
    do_start("rstmid", 32'h0000_4000, 32'h0000_4100);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(ar_q.size() == 4 && rready_m) && cyc < 200);
    chk("rstmid_reach_beat3", {63'd0, cyc >= 200}, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_arvalid", {63'd0, arvalid_m}, 64'd0);
    chk("rstmid_rready", {63'd0, rready_m}, 64'd0);
    chk("rstmid_eoc", {63'd0, eoc}, 64'd1);
    chk("rstmid_araddr", {32'd0, araddr_m}, 64'd0);
    chk("rstmid_vtx", {48'd0, vertexes[0][0] | vertexes[1][2] | vertexes[2][1]}, 64'd0);
    chk("rstmid_colors", {48'd0, colors}, 64'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    run_fetch("post_rst", 32'h0000_5000, 32'h0000_5100, 1, -1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
